seg7_rx_decoder: RTL and testbench

- Receiving end of the seven-segment path: samples a 7-bit active-high segment bus, as driven by our BCD/hex-to-7-segment encoder, and recovers the 4-bit digit value.
- A pattern is accepted only after it has been stable for a programmable number of clocks.
- Each newly accepted pattern produces a one-cycle `o_valid` strobe, classified as hex glyph, blank, or illegal; illegal patterns are counted.
- Used as the loopback checker for encoder outputs in simulation, and for reading back segment lines on hardware.

---
 rtl/seg7_rx_decoder.sv | 140 ++++++++++++++
 tb/tb_seg7_rx_decoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_rx_decoder.sv
// seg7_rx_decoder: recovers a 4-bit digit from a debounced 7-segment bus.
// Ports: i_clk, i_resetn (sync, active-low), i_seg {g..a}, i_en,
//   o_val, o_hex, o_blank, o_err, o_valid, o_locked, o_err_count.
module seg7_rx_decoder #(
   parameter int unsigned STABLE = 4
) (
   input  logic       i_clk,
   input  logic       i_resetn,
   input  logic [6:0] i_seg,
   input  logic       i_en,
   output logic [3:0] o_val,
   output logic       o_hex,
   output logic       o_blank,
   output logic       o_err,
   output logic       o_valid,
   output logic       o_locked,
   output logic [7:0] o_err_count
);

   localparam logic [7:0] STABLE_C = 8'(STABLE);

   typedef enum logic [1:0] {
      EMPTY,
      TRACK,
      HELD
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [6:0] smp;
   logic [6:0] acc;
   logic [7:0] cnt;
   logic [7:0] cnt_nxt;
   logic       same;
   logic       settled;
   logic       accept;
   logic [3:0] cls_val;
   logic       cls_hex;
   logic       cls_blank;
   logic       cls_err;

   // Settling is judged on the count this edge will write, so the
   // acceptance lands on the same edge the count reaches STABLE.
   assign same    = (i_seg == smp);
   assign cnt_nxt = !same               ? 8'd1     :
                    (cnt >= STABLE_C)   ? STABLE_C :
                                          cnt + 8'd1;
   assign settled = (cnt_nxt == STABLE_C);

   always_ff @(posedge i_clk) begin
      if (!i_resetn)
         state <= EMPTY;
      else if (i_en)
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      unique case (state)
         EMPTY: begin
            if (settled) begin
               state_nxt = HELD;
               accept    = 1'b1;
            end
         end
         TRACK: begin
            if (settled) begin
               state_nxt = HELD;
               // Settling back onto the held pattern re-locks silently.
               accept    = (smp != acc);
            end
         end
         HELD: begin
            if (!same)
               state_nxt = TRACK;
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_comb begin
      o_locked  = (state == HELD);
      cls_val   = 4'h0;
      cls_blank = 1'b0;
      cls_err   = 1'b0;
      case (smp)
         7'h3F: cls_val = 4'h0;
         7'h06: cls_val = 4'h1;
         7'h5B: cls_val = 4'h2;
         7'h4F: cls_val = 4'h3;
         7'h66: cls_val = 4'h4;
         7'h6D: cls_val = 4'h5;
         7'h7D: cls_val = 4'h6;
         7'h07: cls_val = 4'h7;
         7'h7F: cls_val = 4'h8;
         7'h6F: cls_val = 4'h9;
         7'h77: cls_val = 4'hA;
         7'h7C: cls_val = 4'hB;
         7'h39: cls_val = 4'hC;
         7'h5E: cls_val = 4'hD;
         7'h79: cls_val = 4'hE;
         7'h71: cls_val = 4'hF;
         7'h00: cls_blank = 1'b1;
         default: cls_err = 1'b1;
      endcase
      cls_hex = (cls_val >= 4'hA);
   end

   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         smp         <= 7'h00;
         cnt         <= 8'd0;
         acc         <= 7'h00;
         o_val       <= 4'h0;
         o_hex       <= 1'b0;
         o_blank     <= 1'b1;
         o_err       <= 1'b0;
         o_valid     <= 1'b0;
         o_err_count <= 8'd0;
      end else begin
         o_valid <= 1'b0;
         if (i_en) begin
            smp <= i_seg;
            cnt <= cnt_nxt;
            if (accept) begin
               acc     <= smp;
               o_valid <= 1'b1;
               o_val   <= cls_val;
               o_hex   <= cls_hex;
               o_blank <= cls_blank;
               o_err   <= cls_err;
               if (cls_err && (o_err_count != 8'hFF))
                  o_err_count <= o_err_count + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_rx_decoder.sv
// tb_seg7_rx_decoder: scoreboard bench for seg7_rx_decoder.
// Reference model works on the raw sample history, not on RTL state.
module tb_seg7_rx_decoder;

   localparam int S = 4;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       en = 1'b0;
   logic [6:0] seg = 7'h00;
   logic [3:0] o_val;
   logic       o_hex;
   logic       o_blank;
   logic       o_err;
   logic       o_valid;
   logic       o_locked;
   logic [7:0] o_err_count;

   always #5 clk = ~clk;

   seg7_rx_decoder #(.STABLE(S)) dut (
      .i_clk       (clk),
      .i_resetn    (resetn),
      .i_seg       (seg),
      .i_en        (en),
      .o_val       (o_val),
      .o_hex       (o_hex),
      .o_blank     (o_blank),
      .o_err       (o_err),
      .o_valid     (o_valid),
      .o_locked    (o_locked),
      .o_err_count (o_err_count)
   );

   typedef struct {
      int         cycle;
      logic [3:0] v;
      bit         h;
      bit         b;
      bit         e;
      int         c;
   } exp_t;

   exp_t sb[$];
   int   edge_no = 0;
   int   n_pass = 0;
   int   n_chk = 0;

   logic [6:0] glyph [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic [6:0] hist[$];
   logic [6:0] m_acc = 7'h00;
   bit         m_have = 0;
   int         m_val = 0;
   bit         m_hex = 0;
   bit         m_blank = 1;
   bit         m_err = 0;
   int         m_cnt = 0;
   bit         m_locked = 0;

   always @(posedge clk) edge_no++;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d at edge %0d",
                  name, act, exp, edge_no);
   endtask

   task automatic model_reset();
      hist.delete();
      m_acc    = 7'h00;
      m_have   = 0;
      m_val    = 0;
      m_hex    = 0;
      m_blank  = 1;
      m_err    = 0;
      m_cnt    = 0;
      m_locked = 0;
   endtask

   // One enabled edge: a pattern is taken when its trailing run of
   // identical samples reaches exactly S and it is new.
   task automatic model_step(input logic [6:0] p, input bit e);
      int   run;
      exp_t x;
      if (!e) return;
      hist.push_back(p);
      if (hist.size() > S + 1) void'(hist.pop_front());
      run = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
         if (hist[i] != p) break;
         run++;
      end
      m_locked = (run >= S);
      if (run == S && (!m_have || p != m_acc)) begin
         m_have  = 1;
         m_acc   = p;
         m_val   = 0;
         m_hex   = 0;
         m_blank = (p == 7'h00);
         m_err   = (p != 7'h00);
         for (int g = 0; g < 16; g++) begin
            if (glyph[g] == p) begin
               m_val = g;
               m_hex = (g >= 10);
               m_err = 0;
            end
         end
         if (m_err && m_cnt < 255) m_cnt++;
         x.cycle = edge_no + 1;
         x.v     = 4'(m_val);
         x.h     = m_hex;
         x.b     = m_blank;
         x.e     = m_err;
         x.c     = m_cnt;
         sb.push_back(x);
      end
   endtask

   task automatic check_state();
      check("locked", int'(o_locked), int'(m_locked));
      check("val", int'(o_val), m_val);
      check("hex", int'(o_hex), int'(m_hex));
      check("blank", int'(o_blank), int'(m_blank));
      check("err", int'(o_err), int'(m_err));
      check("errcnt", int'(o_err_count), m_cnt);
   endtask

   task automatic step(input logic [6:0] p, input bit e);
      @(negedge clk);
      resetn = 1'b1;
      seg    = p;
      en     = e;
      model_step(p, e);
      @(posedge clk);
      #1;
      check_state();
   endtask

   task automatic hold(input logic [6:0] p, input int n);
      repeat (n) step(p, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      en     = 1'($urandom_range(0, 1));
      seg    = 7'($urandom);
      @(posedge clk);
      #1;
      model_reset();
      check("rst_valid", int'(o_valid), 0);
      check_state();
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (o_valid) begin
         if (sb.size() == 0 || sb[0].cycle != edge_no) begin
            n_chk++;
            $display("FAIL strobe: got unexpected o_valid expected none at edge %0d",
                     edge_no);
         end else begin
            x = sb.pop_front();
            check("sb_val", int'(o_val), int'(x.v));
            check("sb_hex", int'(o_hex), int'(x.h));
            check("sb_blank", int'(o_blank), int'(x.b));
            check("sb_err", int'(o_err), int'(x.e));
            check("sb_errcnt", int'(o_err_count), x.c);
         end
      end else if (sb.size() > 0 && sb[0].cycle <= edge_no) begin
         x = sb.pop_front();
         n_chk++;
         $display("FAIL strobe: got no o_valid expected one at edge %0d",
                  x.cycle);
      end
   end

   initial begin
      logic [6:0] p;
      int         len;

      do_reset();
      hold(7'h00, 6);

      for (int g = 0; g < 16; g++) hold(glyph[g], 6);

      hold(7'h5B, 6);
      step(7'h7F, 1'b1);
      hold(7'h5B, 6);

      hold(7'h7F, 3);
      hold(7'h6F, 8);

      for (int i = 0; i < 300; i++) begin
         hold(7'h01, S);
         hold(7'h3F, S);
      end
      check("err_sat", int'(o_err_count), 255);

      hold(7'h4F, 2);
      repeat (5) step(7'h4F, 1'b0);
      hold(7'h4F, 6);
      hold(7'h66, 2);
      do_reset();
      hold(7'h5E, 5);

      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 9))
            7:       p = 7'h00;
            8, 9:    p = 7'($urandom);
            default: p = glyph[$urandom_range(0, 15)];
         endcase
         len = $urandom_range(1, 2 * S);
         for (int k = 0; k < len; k++)
            step(p, $urandom_range(0, 9) != 0);
         if ($urandom_range(0, 49) == 0) do_reset();
      end

      repeat (3) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
